regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, sets the register data width in bits.
REQ-002 Parameter NUM_REGS, default 32, sets the register count; ADDR_W = clog2(NUM_REGS), minimum 1.
REQ-003 Parameter NUM_RD, default 2, sets the number of read ports.
REQ-004 Parameter NUM_WR, default 1, sets the number of write ports, range 1..4.
REQ-005 Parameter ZERO_REG, default 1: when 1, register 0 always reads 0 and ignores writes and reservations.
REQ-006 Parameter BYPASS, default 1: when 1, same-cycle write data is forwarded to the read ports.
REQ-007 clock  in  1  sole clock; all state updates on the rising edge.
REQ-008 resetn  in  1  reset, asynchronous and active-low.
REQ-009 rd_addr  in  NUM_RD*ADDR_W  read addresses, port i in bits [i*ADDR_W +: ADDR_W].
REQ-010 rd_data  out  NUM_RD*DATA_W  read data, combinational, packed per port.
REQ-011 rd_busy  out  NUM_RD  port i's register has an outstanding reservation, combinational.
REQ-012 wr_en  in  NUM_WR  write enables.
REQ-013 wr_addr  in  NUM_WR*ADDR_W  write addresses.
REQ-014 wr_data  in  NUM_WR*DATA_W  write data.
REQ-015 rsv_en  in  1  reserve the destination register of an issued instruction.
REQ-016 rsv_addr  in  ADDR_W  register to reserve.
REQ-017 busy_cnt  out  ADDR_W+1  registered count of currently reserved registers.

Function
REQ-018 Reads are asynchronous: rd_data[i] = regs[rd_addr[i]], and rd_busy[i] = busy[rd_addr[i]].
REQ-019 With ZERO_REG=1, a read of address 0 returns 0 with rd_busy=0, regardless of any write.
REQ-020 With BYPASS=1, a read whose address matches an enabled write port this cycle returns that port's wr_data and rd_busy=0.
REQ-021 With BYPASS=0, reads return the pre-edge contents and pre-edge busy state.
REQ-022 On each rising edge, every enabled write port updates regs[wr_addr] and clears busy[wr_addr].
REQ-023 When several write ports target the same address in one cycle, the highest-numbered port wins for both storage and bypass.
REQ-024 On a rising edge with rsv_en=1, busy[rsv_addr] is set.
REQ-025 When a reservation and a write target the same register in one cycle, the register takes the written data and the busy bit ends set (the new producer wins).
REQ-026 Reserving an already-busy register leaves it busy and does not change busy_cnt.
REQ-027 A write to a non-busy register performs no busy change.
REQ-028 busy_cnt equals the population count of busy[] after each edge.
REQ-029 busy_cnt is maintained incrementally (+1 per new set, -1 per clear) and never wraps; its range is 0..NUM_REGS.
REQ-030 Addresses >= NUM_REGS, when NUM_REGS is not a power of two, are ignored on writes and reservations, and read as 0 with rd_busy=0.

Reset
REQ-031 While resetn=0, all registers are 0, all busy bits are 0, and busy_cnt is 0, independent of clock.
REQ-032 Reset deassertion takes effect at the next rising edge; writes and reservations presented in that cycle are honoured.
REQ-033 Reset asserted mid-operation discards all pending reservations with no further action required.

Structure
REQ-034 A shared package, regfile_pkg, holds the default widths, the clog2 function, and the port-index helper for packed buses.
REQ-035 One sub-module, regfile_wsel, resolves the winning write port per address (REQ-023) and is reused for both storage and bypass.
REQ-036 Storage uses flip-flops, not inferred RAM, because reset is required and multi-write is supported.

Verification
REQ-037 Reset test: write 0xDEADBEEF to r5, assert resetn=0 -> r5 reads 0 immediately and busy_cnt=0.
REQ-038 Zero-register test: write 0x12345678 to r0 with ZERO_REG=1 -> r0 reads 0 and rd_busy=0.
REQ-039 Bypass test: write 0xA5A5A5A5 to r7 with rd_addr[0]=7 in the same cycle -> rd_data[0]=0xA5A5A5A5 in that cycle; repeat with BYPASS=0 -> old value, then the new value after the edge.
REQ-040 Multi-write collision test: with NUM_WR=2, port0 writes 1 and port1 writes 2 to r3 -> r3 reads 2.
REQ-041 Scoreboard test: reserve r4 -> rd_busy=1 and busy_cnt=1; write r4 together with a reserve of r4 -> still busy, busy_cnt=1; write r4 alone -> rd_busy=0 and busy_cnt=0.
REQ-042 Saturation test: reserve all 31 non-zero registers -> busy_cnt=31, and re-reserving any of them leaves it at 31.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers for the multi-port register file
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;

    // Address width for n entries, never less than one bit
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) r = ((1 << i) < n) ? i + 1 : r;
        return (r < 1) ? 1 : r;
    endfunction

    // Low bit of field idx in a packed bus of w-bit fields
    function automatic int lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/regfile_wsel.sv
// regfile_wsel: picks the highest-numbered enabled write port targeting addr
module regfile_wsel
    import regfile_pkg::*;
#(
    parameter int NUM_WR = 1,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]        addr,
    output logic                     hit,
    output logic [DATA_W-1:0]        data
);

    // Ascending scan so later (higher) ports override earlier matches
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && wr_addr[lsb(p, ADDR_W) +: ADDR_W] == addr) begin
                hit  = 1'b1;
                data = wr_data[lsb(p, DATA_W) +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port flip-flop register file with a busy scoreboard
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int ADDR_W   = clog2(NUM_REGS)
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [ADDR_W:0]          busy_cnt
);

    logic [DATA_W-1:0]   regs   [NUM_REGS];
    logic [DATA_W-1:0]   w_data [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [NUM_REGS-1:0] w_hit;
    logic [ADDR_W:0]     cnt_nxt;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        localparam bit LIVE = (ZERO_REG == 0) || (r != 0);
        logic hit;
        regfile_wsel #(
            .NUM_WR(NUM_WR),
            .ADDR_W(ADDR_W),
            .DATA_W(DATA_W)
        ) u_wsel (
            .wr_en  (wr_en),
            .wr_addr(wr_addr),
            .wr_data(wr_data),
            .addr   (ADDR_W'(r)),
            .hit    (hit),
            .data   (w_data[r])
        );
        assign w_hit[r]    = LIVE && hit;
        // A reservation beats a same-cycle write: the new producer owns the register
        assign busy_nxt[r] = LIVE && ((rsv_en && rsv_addr == ADDR_W'(r)) || (busy[r] && !hit));
    end

    // Count moves one step per busy bit that flips, so it tracks the popcount without wrapping
    always_comb begin
        cnt_nxt = busy_cnt;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (busy_nxt[i] && !busy[i]) cnt_nxt = cnt_nxt + 1'b1;
            else if (!busy_nxt[i] && busy[i]) cnt_nxt = cnt_nxt - 1'b1;
        end
    end

    // Storage, busy bits and count; reset clears everything immediately
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) if (w_hit[i]) regs[i] <= w_data[i];
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] b_data;
        logic              b_hit;
        logic              ok;
        logic              fwd;
        assign a = rd_addr[lsb(i, ADDR_W) +: ADDR_W];
        regfile_wsel #(
            .NUM_WR(NUM_WR),
            .ADDR_W(ADDR_W),
            .DATA_W(DATA_W)
        ) u_byp (
            .wr_en  (wr_en),
            .wr_addr(wr_addr),
            .wr_data(wr_data),
            .addr   (a),
            .hit    (b_hit),
            .data   (b_data)
        );
        assign ok  = (32'(a) < NUM_REGS) && !(ZERO_REG != 0 && a == '0);
        assign fwd = (BYPASS != 0) && b_hit;
        assign rd_data[lsb(i, DATA_W) +: DATA_W] = !ok ? '0 : fwd ? b_data : regs[a];
        assign rd_busy[i] = ok && !fwd && busy[a];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for regfile_mp (two configurations)
module tb_regfile_mp;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    // Config A: 32x32, two write ports, bypass on
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [1:0]  a_wr_en;
    logic [9:0]  a_wr_addr;
    logic [63:0] a_wr_data;
    logic        a_rsv_en;
    logic [4:0]  a_rsv_addr;
    logic [5:0]  a_busy_cnt;

    // Config B: 6 registers (non power of two), one write port, bypass off
    logic [5:0]  b_rd_addr;
    logic [63:0] b_rd_data;
    logic [1:0]  b_rd_busy;
    logic [0:0]  b_wr_en;
    logic [2:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic        b_rsv_en;
    logic [2:0]  b_rsv_addr;
    logic [3:0]  b_busy_cnt;

    regfile_mp #(.NUM_WR(2)) dut_a (
        .clock   (clock),
        .resetn  (resetn),
        .rd_addr (a_rd_addr),
        .rd_data (a_rd_data),
        .rd_busy (a_rd_busy),
        .wr_en   (a_wr_en),
        .wr_addr (a_wr_addr),
        .wr_data (a_wr_data),
        .rsv_en  (a_rsv_en),
        .rsv_addr(a_rsv_addr),
        .busy_cnt(a_busy_cnt)
    );

    regfile_mp #(.NUM_REGS(6), .BYPASS(0)) dut_b (
        .clock   (clock),
        .resetn  (resetn),
        .rd_addr (b_rd_addr),
        .rd_data (b_rd_data),
        .rd_busy (b_rd_busy),
        .wr_en   (b_wr_en),
        .wr_addr (b_wr_addr),
        .wr_data (b_wr_data),
        .rsv_en  (b_rsv_en),
        .rsv_addr(b_rsv_addr),
        .busy_cnt(b_busy_cnt)
    );

    task automatic push(input string t, input logic [63:0] v);
        sb.push_back('{t, v});
    endtask

    task automatic chk(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic idle();
        a_wr_en  = '0;
        a_rsv_en = 1'b0;
        b_wr_en  = '0;
        b_rsv_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
        #1;
    endtask

    task automatic a_wr(input int p, input logic [4:0] ad, input logic [31:0] d);
        a_wr_en[p]          = 1'b1;
        a_wr_addr[p*5 +: 5]  = ad;
        a_wr_data[p*32 +: 32] = d;
    endtask

    task automatic a_rsv(input logic [4:0] ad);
        a_rsv_en   = 1'b1;
        a_rsv_addr = ad;
    endtask

    task automatic a_rd(input int p, input logic [4:0] ad);
        a_rd_addr[p*5 +: 5] = ad;
    endtask

    task automatic b_wr(input logic [2:0] ad, input logic [31:0] d);
        b_wr_en   = 1'b1;
        b_wr_addr = ad;
        b_wr_data = d;
    endtask

    task automatic b_rsv(input logic [2:0] ad);
        b_rsv_en   = 1'b1;
        b_rsv_addr = ad;
    endtask

    task automatic b_rd(input int p, input logic [2:0] ad);
        b_rd_addr[p*3 +: 3] = ad;
    endtask

    function automatic logic [31:0] a_dat(input int p);
        return a_rd_data[p*32 +: 32];
    endfunction

    function automatic logic [31:0] b_dat(input int p);
        return b_rd_data[p*32 +: 32];
    endfunction

    initial begin
        idle();
        a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0; a_rsv_addr = '0;
        b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0; b_rsv_addr = '0;
        #1;
        push("reset_cnt", 0);
        chk(a_busy_cnt);
        push("reset_rd", 0);
        chk(a_dat(0));
        @(negedge clock);
        resetn = 1'b1;

        // write r5 and reserve r9, then async reset wipes both
        @(negedge clock);
        a_wr(0, 5, 32'hDEADBEEF); a_rsv(9); a_rd(0, 5);
        push("r5_written", 64'hDEADBEEF);
        push("cnt_after_rsv9", 1);
        tick();
        chk(a_dat(0));
        chk(a_busy_cnt);
        resetn = 1'b0;
        push("async_r5_zero", 0);
        push("async_cnt_zero", 0);
        #1;
        chk(a_dat(0));
        chk(a_busy_cnt);

        // write presented during the deassertion cycle is honoured
        @(negedge clock);
        resetn = 1'b1;
        a_wr(0, 6, 32'h66); a_rd(1, 6);
        push("deassert_write", 64'h66);
        tick();
        chk(a_dat(1));

        // zero register ignores writes and reservations, even when bypassing
        @(negedge clock);
        a_wr(0, 0, 32'h12345678); a_rsv(0); a_rd(0, 0);
        push("r0_bypass_zero", 0);
        push("r0_bypass_busy", 0);
        #1;
        chk(a_dat(0));
        chk(a_rd_busy[0]);
        push("r0_after_zero", 0);
        push("r0_after_cnt", 0);
        tick();
        chk(a_dat(0));
        chk(a_busy_cnt);

        // bypass: reserved r7 written; same-cycle read sees new data, not busy
        @(negedge clock);
        a_rsv(7); a_rd(0, 7);
        push("r7_reserved", 1);
        tick();
        chk(a_rd_busy[0]);
        @(negedge clock);
        a_wr(0, 7, 32'hA5A5A5A5);
        push("bypass_data", 64'hA5A5A5A5);
        push("bypass_busy", 0);
        #1;
        chk(a_dat(0));
        chk(a_rd_busy[0]);
        push("r7_stored", 64'hA5A5A5A5);
        push("r7_cnt_zero", 0);
        tick();
        chk(a_dat(0));
        chk(a_busy_cnt);

        // no bypass: old value and busy until the edge
        @(negedge clock);
        b_wr(2, 32'h1111); b_rsv(2); b_rd(0, 2);
        push("b_r2_first", 64'h1111);
        push("b_r2_busy", 1);
        tick();
        chk(b_dat(0));
        chk(b_rd_busy[0]);
        @(negedge clock);
        b_wr(2, 32'hA5A5A5A5);
        push("nobyp_old", 64'h1111);
        push("nobyp_old_busy", 1);
        #1;
        chk(b_dat(0));
        chk(b_rd_busy[0]);
        push("nobyp_new", 64'hA5A5A5A5);
        push("nobyp_cleared", 0);
        push("b_cnt_zero", 0);
        tick();
        chk(b_dat(0));
        chk(b_rd_busy[0]);
        chk(b_busy_cnt);

        // two ports on r3: port 1 wins in bypass and storage
        @(negedge clock);
        a_wr(0, 3, 32'd1); a_wr(1, 3, 32'd2); a_rd(0, 3);
        push("collide_bypass", 2);
        #1;
        chk(a_dat(0));
        push("collide_stored", 2);
        tick();
        chk(a_dat(0));
        @(negedge clock);
        a_wr(0, 10, 32'hA); a_wr(1, 11, 32'hB); a_rd(0, 10); a_rd(1, 11);
        push("dual_r10", 64'hA);
        push("dual_r11", 64'hB);
        tick();
        chk(a_dat(0));
        chk(a_dat(1));

        // scoreboard sequence on r4
        @(negedge clock);
        a_rsv(4); a_rd(0, 4);
        push("r4_busy", 1);
        push("r4_cnt", 1);
        tick();
        chk(a_rd_busy[0]);
        chk(a_busy_cnt);
        @(negedge clock);
        a_wr(0, 4, 32'h44); a_rsv(4);
        push("r4_wr_rsv_data", 64'h44);
        push("r4_wr_rsv_busy", 1);
        push("r4_wr_rsv_cnt", 1);
        tick();
        chk(a_dat(0));
        chk(a_rd_busy[0]);
        chk(a_busy_cnt);
        @(negedge clock);
        a_wr(0, 4, 32'h45);
        push("r4_final_data", 64'h45);
        push("r4_released", 0);
        push("r4_cnt_zero", 0);
        tick();
        chk(a_dat(0));
        chk(a_rd_busy[0]);
        chk(a_busy_cnt);

        // saturation: every non-zero register reserved
        for (int r = 1; r < 32; r++) begin
            @(negedge clock);
            a_rsv(5'(r));
            tick();
        end
        push("sat_cnt", 31);
        chk(a_busy_cnt);
        @(negedge clock);
        a_rsv(17);
        push("sat_rersv", 31);
        tick();
        chk(a_busy_cnt);
        @(negedge clock);
        a_wr(0, 1, 32'h1); a_wr(1, 2, 32'h2);
        push("double_clear", 29);
        tick();
        chk(a_busy_cnt);
        @(negedge clock);
        a_rsv(3); a_wr(0, 5, 32'h5); a_rd(0, 17);
        push("rersv_and_clear", 28);
        push("r17_busy", 1);
        tick();
        chk(a_busy_cnt);
        chk(a_rd_busy[0]);

        // out-of-range addresses on the 6-entry file
        @(negedge clock);
        b_wr(6, 32'hFF); b_rsv(7); b_rd(0, 6); b_rd(1, 7);
        push("oor_rd6", 0);
        push("oor_rd7", 0);
        push("oor_busy7", 0);
        push("oor_cnt", 0);
        tick();
        chk(b_dat(0));
        chk(b_dat(1));
        chk(b_rd_busy[1]);
        chk(b_busy_cnt);

        // reset mid-operation drops all reservations
        resetn = 1'b0;
        push("midrst_cnt", 0);
        push("midrst_busy", 0);
        #1;
        chk(a_busy_cnt);
        chk(a_rd_busy[0]);

        if (sb.size() != 0) begin
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
